// File: rtl/riscv_pkg.sv
// Shared types for the branch-predictor port arbiter.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // One buffered branch resolution.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            taken;
  } pred_upd_t;

  typedef enum logic [0:0] {
    ARB_NORMAL,
    ARB_DRAIN
  } arb_state_e;

endpackage

// File: rtl/pred_upd_fifo.sv
// Synchronous FIFO of branch resolutions with a synchronous clear.
module pred_upd_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  pred_upd_t                  wdata_i,
  output pred_upd_t                  rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  pred_upd_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Pushes while full and pops while empty are ignored.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy next-state; clear wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/pred_port_arb.sv
// Arbitrates the predictor's single PC port between fetch lookups and
// buffered branch-unit training updates.
module pred_port_arb
  import riscv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_i,
  input  logic                          if_lookup_v_i,
  input  logic [XLEN-1:0]               if_lookup_pc_i,
  output logic                          if_lookup_ready_o,
  output logic                          if_pred_v_o,
  output logic [XLEN-1:0]               if_pred_pc_o,
  output logic                          if_pred_taken_o,
  input  logic                          bu_upd_v_i,
  input  logic [XLEN-1:0]               bu_upd_pc_i,
  input  logic [XLEN-1:0]               bu_upd_target_i,
  input  logic                          bu_upd_taken_i,
  output logic                          bu_upd_ready_o,
  output logic                          pred_en_o,
  output logic [XLEN-1:0]               pred_pc_branch_o,
  output logic [XLEN-1:0]               pred_pc_target_o,
  output logic                          pred_feedback_o,
  output logic                          pred_success_o,
  output logic                          pred_failed_o,
  input  logic [XLEN-1:0]               pred_pc_i,
  input  logic                          pred_taken_i,
  input  logic                          pred_v_i,
  output logic [$clog2(FIFO_DEPTH):0]   upd_count_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          fifo_full, fifo_empty, push, upd_gnt, lk_gnt;
  pred_upd_t     wdata, head;

  assign wdata          = '{pc: bu_upd_pc_i, target: bu_upd_target_i, taken: bu_upd_taken_i};
  assign bu_upd_ready_o = ~fifo_full;
  // A push coinciding with flush is dropped.
  assign push           = bu_upd_v_i & ~fifo_full & ~flush_i;

  pred_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (flush_i),
    .push_i  (push),
    .pop_i   (upd_gnt),
    .wdata_i (wdata),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (upd_count_o)
  );

  // Single-cycle grant: updates win when draining, idle fetch, or starved.
  always_comb begin
    upd_gnt = ~fifo_empty & ((state_q == ARB_DRAIN) | ~if_lookup_v_i |
                             (starve_q == SW'(STARVE_MAX)));
    lk_gnt  = if_lookup_v_i & ~upd_gnt;
  end

  // Shared port mux and fetch-side pass-through.
  always_comb begin
    if_lookup_ready_o = lk_gnt;
    if_pred_v_o       = 1'b0;
    if_pred_pc_o      = '0;
    if_pred_taken_o   = 1'b0;
    pred_en_o         = 1'b0;
    pred_pc_branch_o  = '0;
    pred_pc_target_o  = '0;
    pred_feedback_o   = 1'b0;
    pred_success_o    = 1'b0;
    pred_failed_o     = 1'b0;
    if (upd_gnt) begin
      pred_pc_branch_o = head.pc;
      pred_pc_target_o = head.target;
      pred_feedback_o  = 1'b1;
      pred_success_o   = head.taken;
      pred_failed_o    = ~head.taken;
      // Only taken branches are worth allocating on a miss.
      pred_en_o        = head.taken;
    end else if (lk_gnt) begin
      pred_pc_branch_o = if_lookup_pc_i;
      if_pred_v_o      = pred_v_i;
      if_pred_pc_o     = pred_pc_i;
      if_pred_taken_o  = pred_taken_i;
    end
  end

  // Starvation counter and drain-mode next-state.
  always_comb begin
    starve_d = starve_q;
    state_d  = state_q;
    if (flush_i || upd_gnt || fifo_empty) begin
      starve_d = '0;
    end else if (lk_gnt && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
    unique case (state_q)
      ARB_NORMAL: begin
        if (!flush_i && upd_count_o == CW'(FIFO_DEPTH)) state_d = ARB_DRAIN;
      end
      ARB_DRAIN: begin
        if (flush_i || fifo_empty || (upd_count_o == CW'(1) && upd_gnt && !push)) begin
          state_d = ARB_NORMAL;
        end
      end
      default: state_d = ARB_NORMAL;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule
